// File: rtl/costas_tick_scheduler.sv
// Purpose : Costas loop timing scheduler: per-period tick, offset trigger, divided clock, boundary-aligned reconfig.
// Latency : strobes decode from registered count/state; a valid config word lands one cycle after acceptance (IDLE) or at the next wrap (RUN).
// Backpress: cfg_ready is low only while a shadow config waits for a period boundary (PEND); invalid words are always taken and dropped.
//
// Ports:
//   clockin, resetn            system clock, synchronous active-low reset
//   enable                     run request; low parks the scheduler in IDLE
//   cfg_valid/cfg_ready        config handshake for cfg_period/cfg_trig
//   cfg_err                    one-cycle pulse after an invalid word was discarded
//   cfg_pending                a valid config is waiting for the next boundary
//   tick, trigout, clockout    period start, trigger offset, divided clock level
//   count_out                  current position within the period
module costas_tick_scheduler #(
    parameter int              CNT_W      = 32,
    parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(1000),
    parameter logic [CNT_W-1:0] DEF_TRIG   = CNT_W'(500)
) (
    input  logic             clockin,
    input  logic             resetn,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_trig,
    output logic             cfg_err,
    output logic             cfg_pending,
    output logic             tick,
    output logic             trigout,
    output logic             clockout,
    output logic [CNT_W-1:0] count_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic [CNT_W-1:0] period_act, period_act_nx;
    logic [CNT_W-1:0] trig_act, trig_act_nx;
    logic [CNT_W-1:0] period_sh, period_sh_nx;
    logic [CNT_W-1:0] trig_sh, trig_sh_nx;
    logic             err_q, err_nx;

    logic accept;
    logic cfg_ok;
    logic wrap;
    logic running;

    assign accept  = cfg_valid && cfg_ready;
    assign cfg_ok  = (cfg_period >= CNT_W'(2)) && (cfg_trig < cfg_period);
    assign wrap    = (count == period_act - CNT_W'(1));
    assign running = (state != IDLE);

    always_ff @(posedge clockin) begin
        if (!resetn) begin
            state      <= IDLE;
            count      <= '0;
            period_act <= DEF_PERIOD;
            trig_act   <= DEF_TRIG;
            period_sh  <= DEF_PERIOD;
            trig_sh    <= DEF_TRIG;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            period_act <= period_act_nx;
            trig_act   <= trig_act_nx;
            period_sh  <= period_sh_nx;
            trig_sh    <= trig_sh_nx;
            err_q      <= err_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        count_nx      = count;
        period_act_nx = period_act;
        trig_act_nx   = trig_act;
        period_sh_nx  = period_sh;
        trig_sh_nx    = trig_sh;
        // Invalid words never touch state or registers, even on a wrap cycle.
        err_nx        = accept && !cfg_ok;

        unique case (state)
            IDLE: begin
                count_nx = '0;
                if (accept && cfg_ok) begin
                    period_act_nx = cfg_period;
                    trig_act_nx   = cfg_trig;
                end
                if (enable) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    // Stopping: no boundary to wait for, so a new word goes straight in.
                    state_nx = IDLE;
                    count_nx = '0;
                    if (accept && cfg_ok) begin
                        period_act_nx = cfg_period;
                        trig_act_nx   = cfg_trig;
                    end
                end else begin
                    count_nx = wrap ? '0 : count + CNT_W'(1);
                    if (accept && cfg_ok) begin
                        period_sh_nx = cfg_period;
                        trig_sh_nx   = cfg_trig;
                        state_nx     = PEND;
                    end
                end
            end
            PEND: begin
                if (!enable) begin
                    state_nx      = IDLE;
                    count_nx      = '0;
                    period_act_nx = period_sh;
                    trig_act_nx   = trig_sh;
                end else begin
                    count_nx = wrap ? '0 : count + CNT_W'(1);
                    // Swap on the wrap so the count=0 cycle already uses the new period.
                    if (wrap) begin
                        period_act_nx = period_sh;
                        trig_act_nx   = trig_sh;
                        state_nx      = RUN;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                count_nx = '0;
            end
        endcase
    end

    assign cfg_ready   = (state != PEND);
    assign cfg_pending = (state == PEND);
    assign cfg_err     = err_q;
    assign count_out   = count;
    assign tick        = running && (count == '0);
    assign trigout     = running && (count == trig_act);
    assign clockout    = running && (count < (period_act >> 1));

endmodule
